// File: rtl/huff_pkg.sv
// Shared definitions for the canonical Huffman decoder: configuration
// table selectors and the configuration address width rule.
package huff_pkg;

   typedef enum logic {
      CFG_CNT = 1'b0,
      CFG_SYM = 1'b1
   } cfg_sel_e;

   // Address must reach both cnt[1..max_len] and sym[0..2**sym_w-1].
   function automatic int cfg_aw(input int max_len, input int sym_w);
      int len_aw;
      len_aw = $clog2(max_len + 1);
      return (len_aw > sym_w) ? len_aw : sym_w;
   endfunction

endpackage

// File: rtl/huff_cfg_tables.sv
// Length-count and symbol tables for the canonical Huffman decoder,
// written through the configuration port and read combinationally.
module huff_cfg_tables
   import huff_pkg::*;
#(
   parameter int SYM_W   = 3,
   parameter int MAX_LEN = 8,
   parameter int CFG_AW  = cfg_aw(MAX_LEN, SYM_W),
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [SYM_W:0]    cfg_data,
   input  logic [LEN_W-1:0]  rd_len,
   input  logic [SYM_W-1:0]  rd_addr,
   output logic [SYM_W:0]    cnt_val,
   output logic [SYM_W-1:0]  sym_val
);

   localparam logic [CFG_AW-1:0] ADDR_MAX = CFG_AW'(MAX_LEN);

   logic [SYM_W:0]   cnt_mem [1:MAX_LEN];
   logic [SYM_W-1:0] sym_mem [0:(2**SYM_W)-1];

   logic cnt_wr_ok;
   logic sym_wr_ok;

   assign cnt_wr_ok = (cfg_addr != '0) && (cfg_addr <= ADDR_MAX);
   assign sym_wr_ok = (cfg_addr >> SYM_W) == '0;

   // NOTE: the tables are reset explicitly because a cleared table has a
   // defined decode behaviour (every MAX_LEN bits yield one error), so
   // this storage must be flops, not an uninitialised RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= MAX_LEN; i++) cnt_mem[i] <= '0;
         for (int i = 0; i < 2**SYM_W; i++) sym_mem[i] <= '0;
      end else if (cfg_we) begin
         if (cfg_sel == CFG_CNT) begin
            if (cnt_wr_ok) cnt_mem[cfg_addr[LEN_W-1:0]] <= cfg_data;
         end else begin
            if (sym_wr_ok) sym_mem[cfg_addr[SYM_W-1:0]] <= cfg_data[SYM_W-1:0];
         end
      end
   end

   assign cnt_val = cnt_mem[rd_len];
   assign sym_val = sym_mem[rd_addr];

endmodule

// File: rtl/huffman_decoder_canon.sv
// Bit-serial canonical Huffman decoder: one code bit per accepted beat,
// symbol or invalid-code flag registered one cycle after the final bit.
module huffman_decoder_canon
   import huff_pkg::*;
#(
   parameter int SYM_W   = 3,
   parameter int MAX_LEN = 8,
   localparam int CFG_AW = cfg_aw(MAX_LEN, SYM_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_bit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SYM_W-1:0]  out_sym,
   output logic              out_err,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              cfg_we,
   input  logic              cfg_sel,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [SYM_W:0]    cfg_data
);

   localparam int CW    = MAX_LEN + 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int DW    = (CW > SYM_W + 1) ? CW : SYM_W + 1;

   logic [CW-1:0]    code_q, first_q;
   logic [SYM_W:0]   index_q;
   logic [LEN_W-1:0] len_q;

   logic [CW-1:0]    code_cur, diff;
   logic [DW-1:0]    diff_w;
   logic [SYM_W:0]   cnt_val;
   logic [SYM_W-1:0] sym_addr, sym_val;
   logic             accept, hit, last;

   huff_cfg_tables #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .CFG_AW  (CFG_AW),
      .LEN_W   (LEN_W)
   ) u_tables (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .rd_len   (len_q),
      .rd_addr  (sym_addr),
      .cnt_val  (cnt_val),
      .sym_val  (sym_val)
   );

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // Codes of the current length occupy [first, first + cnt[len]).
   assign code_cur = code_q | CW'(in_bit);
   assign diff     = code_cur - first_q;
   assign diff_w   = DW'(diff);
   assign hit      = diff_w < DW'(cnt_val);
   assign last     = len_q == LEN_W'(MAX_LEN);
   assign sym_addr = SYM_W'(DW'(index_q) + diff_w);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         code_q    <= '0;
         first_q   <= '0;
         index_q   <= '0;
         len_q     <= LEN_W'(1);
         out_sym   <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         // NOTE: a result loaded below overrides this clear because the
         // last non-blocking assignment in the block wins.
         if (out_valid && out_ready) out_valid <= 1'b0;

         if (cfg_we) begin
            code_q  <= '0;
            first_q <= '0;
            index_q <= '0;
            len_q   <= LEN_W'(1);
         end else if (accept) begin
            if (hit || last) begin
               out_sym   <= hit ? sym_val : '0;
               out_err   <= ~hit;
               out_valid <= 1'b1;
               code_q    <= '0;
               first_q   <= '0;
               index_q   <= '0;
               len_q     <= LEN_W'(1);
            end else begin
               index_q <= index_q + cnt_val;
               first_q <= (first_q + CW'(cnt_val)) << 1;
               code_q  <= code_cur << 1;
               len_q   <= len_q + LEN_W'(1);
            end
         end
      end
   end

endmodule
